// File: rtl/mpres_pkg.sv
// Shared types and helpers for the multiple-prescaler controller.
package mpres_pkg;

    typedef enum logic [1:0] {
        CH_OFF,
        CH_RUN,
        CH_OFF_PEND,
        CH_RUN_PEND
    } chan_state_t;

    localparam int unsigned EW_DEF = 5;

    // Requested exponents beyond the counter width divide by the full counter range.
    function automatic int unsigned sat_exp(input int unsigned e, input int unsigned cw);
        return (e > cw) ? cw : e;
    endfunction

endpackage

// File: rtl/mpres_chan.sv
// One prescaler channel: run/off FSM with a single pending config slot,
// boundary-aligned apply, and registered square-wave / tick outputs.
module mpres_chan
    import mpres_pkg::*;
#(
    parameter int CW = 24,
    parameter int EW = EW_DEF
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic [CW-1:0] cnt,
    input  logic          wr,
    input  logic          wr_en,
    input  logic [EW-1:0] wr_exp,
    output logic          pend,
    output logic          D,
    output logic          tick
);

    chan_state_t   state, state_nx;
    logic [EW-1:0] cur_exp, cur_exp_nx;
    logic [EW-1:0] pend_exp, pend_exp_nx;
    logic          pend_en, pend_en_nx;

    logic [CW-1:0] cur_mask, new_mask;
    logic          cur_bnd, new_bnd, running;
    logic          wr_run;
    logic [EW-1:0] wr_exp_sat;
    logic          d_nx, tick_nx;

    // Low-bit mask for exponent e; e == 0 yields an empty mask (always at a boundary).
    function automatic logic [CW-1:0] mask_of(input logic [EW-1:0] e);
        logic [CW:0] one_hot;
        logic [CW:0] m;
        one_hot = {{CW{1'b0}}, 1'b1} << e;
        m       = one_hot - 1'b1;
        return m[CW-1:0];
    endfunction

    assign wr_exp_sat = EW'(sat_exp(32'(wr_exp), CW));
    assign wr_run     = wr_en && (wr_exp != '0);

    assign cur_mask = mask_of(cur_exp);
    assign new_mask = mask_of(pend_exp);
    assign cur_bnd  = (cnt & cur_mask) == cur_mask;
    assign new_bnd  = (cnt & new_mask) == new_mask;
    assign running  = (state == CH_RUN) || (state == CH_RUN_PEND);
    assign pend     = (state == CH_OFF_PEND) || (state == CH_RUN_PEND);

    // mask ^ (mask >> 1) is one-hot on bit e-1, giving cnt[e-1] without a variable index.
    assign d_nx    = running && |(cnt & (cur_mask ^ (cur_mask >> 1)));
    assign tick_nx = running && ((cnt & cur_mask) == '0);

    always_comb begin
        state_nx    = state;
        cur_exp_nx  = cur_exp;
        pend_en_nx  = pend_en;
        pend_exp_nx = pend_exp;
        case (state)
            CH_OFF, CH_RUN: begin
                if (wr) begin
                    state_nx    = (state == CH_OFF) ? CH_OFF_PEND : CH_RUN_PEND;
                    pend_en_nx  = wr_run;
                    pend_exp_nx = wr_run ? wr_exp_sat : '0;
                end
            end
            CH_OFF_PEND, CH_RUN_PEND: begin
                if ((state == CH_OFF_PEND) ? new_bnd : cur_bnd) begin
                    if (pend_en) begin
                        state_nx   = CH_RUN;
                        cur_exp_nx = pend_exp;
                    end else begin
                        state_nx   = CH_OFF;
                    end
                end
            end
            default: state_nx = CH_OFF;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= CH_OFF;
            cur_exp  <= '0;
            pend_en  <= 1'b0;
            pend_exp <= '0;
            D        <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state    <= state_nx;
            cur_exp  <= cur_exp_nx;
            pend_en  <= pend_en_nx;
            pend_exp <= pend_exp_nx;
            D        <= d_nx;
            tick     <= tick_nx;
        end
    end

endmodule

// File: rtl/mpres_ctrl.sv
// Multiple-prescaler controller: shared free-running counter, config
// req/ack decode and NCH boundary-synchronised prescaler channels.
module mpres_ctrl
    import mpres_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 24,
    parameter int EW  = EW_DEF,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_in,
    input  logic           rst,
    input  logic           cfg_wr,
    input  logic [CHW-1:0] cfg_ch,
    input  logic           cfg_en,
    input  logic [EW-1:0]  cfg_exp,
    output logic           cfg_ack,
    output logic           busy,
    output logic [NCH-1:0] D,
    output logic [NCH-1:0] tick
);

    logic [CW-1:0]  cnt;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] wr_sel;
    logic           accept;

    // A request is taken only when its channel's pending slot is free; otherwise
    // the requester keeps cfg_wr high and is accepted once the slot drains.
    assign accept = cfg_wr && (32'(cfg_ch) < 32'(NCH)) && !pend[cfg_ch];
    assign busy   = |pend;

    always_comb begin
        wr_sel = '0;
        if (accept) wr_sel[cfg_ch] = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            cfg_ack <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            cfg_ack <= accept;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        mpres_chan #(
            .CW(CW),
            .EW(EW)
        ) u_chan (
            .clk_in (clk_in),
            .rst    (rst),
            .cnt    (cnt),
            .wr     (wr_sel[i]),
            .wr_en  (cfg_en),
            .wr_exp (cfg_exp),
            .pend   (pend[i]),
            .D      (D[i]),
            .tick   (tick[i])
        );
    end

endmodule

// File: tb/tb_mpres_ctrl.sv
// Directed self-checking bench for mpres_ctrl (NCH=4, CW=24, EW=5).
module tb_mpres_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic       cfg_en = 1'b0;
    logic [4:0] cfg_exp = '0;
    logic       cfg_ack, busy;
    logic [3:0] D, tick;

    int total = 0;
    int bad = 0;

    // Reference cycle count since reset release; equals the DUT counter at the negedge.
    logic [23:0] tcnt;

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or posedge rst) begin
        if (rst) tcnt <= '0;
        else     tcnt <= tcnt + 24'd1;
    end

    mpres_ctrl #(.NCH(4), .CW(24), .EW(5)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .cfg_wr (cfg_wr),
        .cfg_ch (cfg_ch),
        .cfg_en (cfg_en),
        .cfg_exp(cfg_exp),
        .cfg_ack(cfg_ack),
        .busy   (busy),
        .D      (D),
        .tick   (tick)
    );

    task automatic do_write(input int ch, input logic en, input logic [4:0] e, output logic [23:0] t_ack);
        logic got;
        got = 1'b0;
        cfg_ch = 2'(ch); cfg_en = en; cfg_exp = e; cfg_wr = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk_in);
            if (cfg_ack === 1'b1) begin got = 1'b1; break; end
        end
        t_ack = tcnt;
        cfg_wr = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL ack_timeout ch%0d: got ack=0 want ack=1", ch); end
        @(negedge clk_in);
        total++;
        if (cfg_ack !== 1'b0) begin bad++; $display("FAIL ack_pulse ch%0d: got %b want 0", ch, cfg_ack); end
    endtask

    task automatic wait_idle(input int limit);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (busy === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk_in);
        end
        total++;
        if (!ok) begin bad++; $display("FAIL idle_timeout: got busy=%b want 0", busy); end
    endtask

    task automatic align(input logic [3:0] mask, input logic [3:0] val);
        for (int k = 0; k < 16; k++) begin
            if ((tcnt[3:0] & mask) == val) break;
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk_in);
        total++;
        if ({D, tick, cfg_ack, busy} !== 10'b0) begin
            bad++; $display("FAIL reset_hold: got %b want 0", {D, tick, cfg_ack, busy});
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in);
            total++;
            if ({D, tick, cfg_ack, busy} !== 10'b0) begin
                bad++; $display("FAIL reset_idle: got %b want 0", {D, tick, cfg_ack, busy});
            end
        end
    endtask

    task automatic test_div2;
        logic [23:0] t, p;
        do_write(0, 1'b1, 5'd1, t);
        wait_idle(16);
        repeat (2) @(negedge clk_in);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            p = tcnt - 24'd1;
            total++;
            if (D[0] !== p[0] || tick[0] !== ~p[0]) begin
                bad++; $display("FAIL div2 p=%0d: got D=%b tick=%b want D=%b tick=%b", p, D[0], tick[0], p[0], ~p[0]);
            end
        end
        total++;
        if (D[3:1] !== 3'b0) begin bad++; $display("FAIL div2_others: got %b want 000", D[3:1]); end
    endtask

    task automatic test_mid_change;
        logic [23:0] t, a, p;
        logic exp_d, exp_t, prev, first;
        int e, run;
        do_write(2, 1'b1, 5'd3, t);
        wait_idle(32);
        repeat (2) @(negedge clk_in);
        align(4'h7, 4'h2);
        do_write(2, 1'b1, 5'd2, t);
        a = t;
        for (int k = 0; k < 8; k++) if (a[2:0] != 3'b111) a = a + 24'd1;
        prev = D[2]; run = 1; first = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk_in);
            p = tcnt - 24'd1;
            e = (p <= a) ? 3 : 2;
            exp_d = p[e-1];
            exp_t = (e == 3) ? (p[2:0] == 3'd0) : (p[1:0] == 2'd0);
            total++;
            if (D[2] !== exp_d || tick[2] !== exp_t) begin
                bad++; $display("FAIL mid_change p=%0d: got D=%b tick=%b want D=%b tick=%b", p, D[2], tick[2], exp_d, exp_t);
            end
            if (D[2] === prev) run++;
            else begin
                if (!first) begin
                    total++;
                    if (run < 2) begin bad++; $display("FAIL runt p=%0d: got run=%0d want >=2", p, run); end
                end
                first = 1'b0; run = 1; prev = D[2];
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] t, a, t2;
        logic got;
        align(4'hF, 4'h3);
        do_write(1, 1'b1, 5'd4, t);
        a = t;
        for (int k = 0; k < 16; k++) if (a[3:0] != 4'hF) a = a + 24'd1;
        cfg_ch = 2'd1; cfg_en = 1'b1; cfg_exp = 5'd4; cfg_wr = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (cfg_ack === 1'b1) begin got = 1'b1; break; end
            if (tcnt <= a) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy t=%0d: got %b want 1", tcnt, busy); end
            end
        end
        t2 = tcnt;
        cfg_wr = 1'b0;
        total++;
        if (!got || t2 !== a + 24'd2) begin
            bad++; $display("FAIL b2b_ack_time: got t=%0d ack=%b want t=%0d ack=1", t2, got, a + 24'd2);
        end
        total++;
        if (tick[1] !== 1'b1 || D[1] !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_first_apply: got tick=%b D=%b busy=%b want 1 0 1", tick[1], D[1], busy);
        end
        for (int k = 0; k < 20; k++) begin
            if (tcnt == a + 24'd16) break;
            @(negedge clk_in);
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_pend: got %b want 1", busy); end
        @(negedge clk_in);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_second_apply: got %b want 0", busy); end
    endtask

    task automatic test_stop;
        logic [23:0] t, a, p;
        logic exp_d, exp_t;
        do_write(3, 1'b1, 5'd4, t);
        wait_idle(40);
        repeat (2) @(negedge clk_in);
        align(4'hF, 4'h5);
        do_write(3, 1'b0, 5'd4, t);
        a = t;
        for (int k = 0; k < 16; k++) if (a[3:0] != 4'hF) a = a + 24'd1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            p = tcnt - 24'd1;
            exp_d = (p <= a) ? p[3] : 1'b0;
            exp_t = (p <= a) ? (p[3:0] == 4'd0) : 1'b0;
            total++;
            if (D[3] !== exp_d || tick[3] !== exp_t) begin
                bad++; $display("FAIL stop p=%0d: got D=%b tick=%b want D=%b tick=%b", p, D[3], tick[3], exp_d, exp_t);
            end
        end
        // exponent 0 behaves as a stop request
        do_write(3, 1'b1, 5'd4, t);
        wait_idle(40);
        repeat (2) @(negedge clk_in);
        p = tcnt - 24'd1;
        total++;
        if (D[3] !== p[3]) begin bad++; $display("FAIL restart: got D=%b want %b", D[3], p[3]); end
        do_write(3, 1'b1, 5'd0, t);
        wait_idle(40);
        repeat (2) @(negedge clk_in);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            total++;
            if (D[3] !== 1'b0 || tick[3] !== 1'b0) begin
                bad++; $display("FAIL exp0_off: got D=%b tick=%b want 0 0", D[3], tick[3]);
            end
        end
        // exponent 31 saturates to 24: runs, but never reaches a boundary within this run
        do_write(3, 1'b1, 5'd4, t);
        wait_idle(40);
        do_write(3, 1'b1, 5'd31, t);
        wait_idle(40);
        repeat (2) @(negedge clk_in);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            total++;
            if (D[3] !== 1'b0 || tick[3] !== 1'b0) begin
                bad++; $display("FAIL exp31_quiet: got D=%b tick=%b want 0 0", D[3], tick[3]);
            end
        end
        do_write(3, 1'b1, 5'd4, t);
        repeat (40) @(negedge clk_in);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL exp31_long_period: got busy=%b want 1", busy); end
    endtask

    task automatic test_reset_mid;
        logic [23:0] t;
        align(4'hF, 4'h3);
        do_write(1, 1'b1, 5'd1, t);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rmid_pending: got busy=%b want 1", busy); end
        @(negedge clk_in);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({D, tick, cfg_ack, busy} !== 10'b0) begin
            bad++; $display("FAIL rmid_async: got %b want 0", {D, tick, cfg_ack, busy});
        end
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            total++;
            if ({D, tick, cfg_ack, busy} !== 10'b0) begin
                bad++; $display("FAIL rmid_after t=%0d: got %b want 0", tcnt, {D, tick, cfg_ack, busy});
            end
        end
    endtask

    initial begin
        test_reset;
        test_div2;
        test_mid_change;
        test_back_to_back;
        test_stop;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
